// File: rtl/hazard_scoreboard.sv
// Per-register RAW/WAW hazard scoreboard beside decode: load countdowns plus one
// in-flight mult/div, producing a combinational decode stall.
module hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         decode_ir,
    input  logic                issue,
    input  logic                md_done,
    output logic                stall,
    output logic                md_busy,
    output logic [NUM_REGS-1:0] pending_mask
);

    typedef enum logic [4:0] {
        OP_RTYPE = 5'b00000,
        OP_BNE   = 5'b00010,
        OP_JAL   = 5'b00011,
        OP_JR    = 5'b00100,
        OP_ADDI  = 5'b00101,
        OP_BLT   = 5'b00110,
        OP_SW    = 5'b00111,
        OP_LW    = 5'b01000,
        OP_SETX  = 5'b10101,
        OP_BEX   = 5'b10110
    } opcode_t;

    logic [4:0]       opcode, rd, rs, rt, aluop;
    logic [REG_W-1:0] src_a, src_b, dst, md_rd;
    logic             src_a_v, src_b_v, dst_v;
    logic             is_lw, is_md, go, md_live;
    logic             load_raw, md_raw, waw, structural;
    logic [CNT_W-1:0] cnt [NUM_REGS];
    logic             unused_ir_bits;

    assign opcode = decode_ir[31:27];
    assign rd     = decode_ir[26:22];
    assign rs     = decode_ir[21:17];
    assign rt     = decode_ir[16:12];
    assign aluop  = decode_ir[6:2];
    assign unused_ir_bits = ^{decode_ir[11:7], decode_ir[1:0]};

    assign is_lw = (opcode == OP_LW);
    assign is_md = (opcode == OP_RTYPE) && (aluop == 5'b00110 || aluop == 5'b00111);

    // Operand selection; any operand naming r0 is dropped so it can never match state.
    always_comb begin
        src_a   = '0;
        src_b   = '0;
        dst     = '0;
        src_a_v = 1'b0;
        src_b_v = 1'b0;
        dst_v   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                src_a = REG_W'(rs); src_a_v = 1'b1;
                src_b = REG_W'(rt); src_b_v = 1'b1;
                dst   = REG_W'(rd); dst_v   = 1'b1;
            end
            OP_ADDI, OP_LW: begin
                src_a = REG_W'(rs); src_a_v = 1'b1;
                dst   = REG_W'(rd); dst_v   = 1'b1;
            end
            OP_SW, OP_BNE, OP_BLT: begin
                src_a = REG_W'(rs); src_a_v = 1'b1;
                src_b = REG_W'(rd); src_b_v = 1'b1;
            end
            OP_JR:   begin src_a = REG_W'(rd); src_a_v = 1'b1; end
            OP_BEX:  begin src_a = REG_W'(30); src_a_v = 1'b1; end
            OP_JAL:  begin dst = REG_W'(31); dst_v = 1'b1; end
            OP_SETX: begin dst = REG_W'(30); dst_v = 1'b1; end
            default: ;
        endcase
        src_a_v = src_a_v && (src_a != '0);
        src_b_v = src_b_v && (src_b != '0);
        dst_v   = dst_v && (dst != '0);
    end

    always_comb begin
        load_raw = 1'b0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            if (cnt[r] != '0 &&
                ((src_a_v && src_a == REG_W'(r)) || (src_b_v && src_b == REG_W'(r))))
                load_raw = 1'b1;
        end
    end

    // md_done forwards the result this cycle, so it lifts all mult/div hazards.
    assign md_live    = md_busy && !md_done;
    assign md_raw     = md_live && ((src_a_v && src_a == md_rd) || (src_b_v && src_b == md_rd));
    assign waw        = md_live && dst_v && (dst == md_rd);
    assign structural = md_live && is_md;
    assign stall      = load_raw || md_raw || waw || structural;
    assign go         = issue && !stall;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++)
                cnt[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (r == 0)
                    cnt[r] <= '0;
                else if (go && is_lw && dst_v && dst == REG_W'(r))
                    cnt[r] <= CNT_W'(LOAD_LAT);
                else if (cnt[r] != '0)
                    cnt[r] <= cnt[r] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            md_busy <= 1'b0;
            md_rd   <= '0;
        end else if (go && is_md && dst_v) begin
            md_busy <= 1'b1;
            md_rd   <= dst;
        end else if (md_done) begin
            md_busy <= 1'b0;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++)
            pending_mask[r] = (cnt[r] != '0) || (md_busy && md_rd == REG_W'(r));
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: directed stimulus queues expected stall/md_busy/pending_mask,
// a monitor pops and compares on every sample strobe.
module tb_hazard_scoreboard;

    logic        clock;
    logic        reset;
    logic [31:0] decode_ir;
    logic        issue;
    logic        md_done;
    logic        stall_a, busy_a, stall_b, busy_b;
    logic [31:0] mask_a, mask_b;

    typedef struct packed {
        logic        sel;
        logic        stall;
        logic        busy;
        logic [31:0] mask;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    event  sample_ev;
    int    vectors = 0;
    int    miscompares = 0;

    hazard_scoreboard #(.NUM_REGS(32), .REG_W(5), .LOAD_LAT(1), .CNT_W(2)) dut_a (
        .clock(clock), .reset(reset), .decode_ir(decode_ir), .issue(issue),
        .md_done(md_done), .stall(stall_a), .md_busy(busy_a), .pending_mask(mask_a)
    );

    hazard_scoreboard #(.NUM_REGS(32), .REG_W(5), .LOAD_LAT(2), .CNT_W(2)) dut_b (
        .clock(clock), .reset(reset), .decode_ir(decode_ir), .issue(issue),
        .md_done(md_done), .stall(stall_b), .md_busy(busy_b), .pending_mask(mask_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mk(input logic [4:0] op, rd, rs, rt, aluop);
        return {op, rd, rs, rt, 5'b0, aluop, 2'b0};
    endfunction
    function automatic logic [31:0] add_i(input logic [4:0] rd, rs, rt);
        return mk(5'b00000, rd, rs, rt, 5'b00000);
    endfunction
    function automatic logic [31:0] mul_i(input logic [4:0] rd, rs, rt);
        return mk(5'b00000, rd, rs, rt, 5'b00110);
    endfunction
    function automatic logic [31:0] div_i(input logic [4:0] rd, rs, rt);
        return mk(5'b00000, rd, rs, rt, 5'b00111);
    endfunction
    function automatic logic [31:0] lw_i(input logic [4:0] rd, rs);
        return mk(5'b01000, rd, rs, 5'd0, 5'd0);
    endfunction
    function automatic logic [31:0] sw_i(input logic [4:0] rd, rs);
        return mk(5'b00111, rd, rs, 5'd0, 5'd0);
    endfunction
    function automatic logic [31:0] addi_i(input logic [4:0] rd, rs);
        return mk(5'b00101, rd, rs, 5'd0, 5'd0);
    endfunction
    function automatic logic [31:0] bit_of(input int r);
        return 32'h1 << r;
    endfunction

    task automatic drive(input logic [31:0] ir, input logic iss, input logic done);
        decode_ir = ir;
        issue     = iss;
        md_done   = done;
        #1;
    endtask

    task automatic expect_out(input string name, input logic sel, input logic st,
                              input logic busy, input logic [31:0] mask);
        exp_t e;
        e.sel = sel; e.stall = st; e.busy = busy; e.mask = mask;
        exp_q.push_back(e);
        name_q.push_back(name);
        -> sample_ev;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
    endtask

    // Monitor: compares DUT outputs against the oldest queued expectation.
    initial begin
        exp_t  e;
        string n;
        logic  st, bz;
        logic [31:0] mk_v;
        forever begin
            @(sample_ev);
            e = exp_q.pop_front();
            n = name_q.pop_front();
            st   = e.sel ? stall_b : stall_a;
            bz   = e.sel ? busy_b  : busy_a;
            mk_v = e.sel ? mask_b  : mask_a;
            vectors++;
            if (st !== e.stall || bz !== e.busy || mk_v !== e.mask) begin
                miscompares++;
                $display("FAIL %s: got stall=%b md_busy=%b mask=%h, want stall=%b md_busy=%b mask=%h",
                         n, st, bz, mk_v, e.stall, e.busy, e.mask);
            end
        end
    end

    initial begin
        reset = 1'b1;
        decode_ir = add_i(5'd6, 5'd5, 5'd1);
        issue = 1'b0;
        md_done = 1'b0;
        @(negedge clock);
        #1;
        expect_out("reset_a", 1'b0, 1'b0, 1'b0, 32'h0);
        expect_out("reset_b", 1'b1, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        tick();

        // load-use with LOAD_LAT=1
        drive(lw_i(5'd5, 5'd2), 1'b1, 1'b0);
        expect_out("lu_lw_issue", 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(add_i(5'd6, 5'd5, 5'd1), 1'b1, 1'b0);
        expect_out("lu_bubble", 1'b0, 1'b1, 1'b0, bit_of(5));
        tick();
        drive(add_i(5'd6, 5'd5, 5'd1), 1'b1, 1'b0);
        expect_out("lu_release", 1'b0, 1'b0, 1'b0, 32'h0);
        tick();

        // LOAD_LAT=2: two bubbles for a store reading the load result
        pulse_reset();
        drive(lw_i(5'd7, 5'd3), 1'b1, 1'b0);
        expect_out("l2_lw_issue", 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive(sw_i(5'd7, 5'd3), 1'b1, 1'b0);
        expect_out("l2_sw_stall1", 1'b1, 1'b1, 1'b0, bit_of(7));
        tick();
        expect_out("l2_sw_stall2", 1'b1, 1'b1, 1'b0, bit_of(7));
        tick();
        expect_out("l2_sw_release", 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        pulse_reset();
        drive(lw_i(5'd7, 5'd3), 1'b1, 1'b0);
        tick();
        drive(add_i(5'd8, 5'd9, 5'd10), 1'b1, 1'b0);
        expect_out("l2_indep", 1'b1, 1'b0, 1'b0, bit_of(7));
        tick();

        // mult/div RAW held until md_done, bypassed in the done cycle
        pulse_reset();
        drive(mul_i(5'd4, 5'd1, 5'd2), 1'b1, 1'b0);
        expect_out("md_issue", 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        drive(add_i(5'd3, 5'd4, 5'd4), 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            expect_out($sformatf("md_raw_hold%0d", i), 1'b0, 1'b1, 1'b1, bit_of(4));
            tick();
        end
        drive(add_i(5'd3, 5'd4, 5'd4), 1'b1, 1'b1);
        expect_out("md_done_bypass", 1'b0, 1'b0, 1'b1, bit_of(4));
        tick();
        drive(32'h0, 1'b0, 1'b0);
        expect_out("md_cleared", 1'b0, 1'b0, 1'b0, 32'h0);
        tick();

        // structural and WAW, then back-to-back mult/div in the done cycle
        pulse_reset();
        drive(mul_i(5'd4, 5'd1, 5'd2), 1'b1, 1'b0);
        tick();
        drive(div_i(5'd9, 5'd1, 5'd2), 1'b1, 1'b0);
        expect_out("structural", 1'b0, 1'b1, 1'b1, bit_of(4));
        tick();
        drive(addi_i(5'd4, 5'd0), 1'b1, 1'b0);
        expect_out("waw", 1'b0, 1'b1, 1'b1, bit_of(4));
        tick();
        drive(mul_i(5'd12, 5'd1, 5'd2), 1'b1, 1'b1);
        expect_out("md_reissue", 1'b0, 1'b0, 1'b1, bit_of(4));
        tick();
        drive(32'h0, 1'b0, 1'b0);
        expect_out("md_new_rd", 1'b0, 1'b0, 1'b1, bit_of(12));
        drive(add_i(5'd3, 5'd12, 5'd0), 1'b0, 1'b0);
        expect_out("md_new_raw", 1'b0, 1'b1, 1'b1, bit_of(12));
        drive(addi_i(5'd4, 5'd0), 1'b0, 1'b0);
        expect_out("md_old_rd_free", 1'b0, 1'b0, 1'b1, bit_of(12));
        tick();

        // register 0 is never tracked; a reissued load reloads its counter
        pulse_reset();
        drive(lw_i(5'd0, 5'd2), 1'b1, 1'b0);
        tick();
        drive(add_i(5'd1, 5'd0, 5'd0), 1'b0, 1'b0);
        expect_out("r0_load", 1'b0, 1'b0, 1'b0, 32'h0);
        drive(lw_i(5'd5, 5'd2), 1'b1, 1'b0);
        tick();
        drive(add_i(5'd8, 5'd9, 5'd10), 1'b1, 1'b0);
        expect_out("reload_gap", 1'b0, 1'b0, 1'b0, bit_of(5));
        tick();
        drive(lw_i(5'd5, 5'd2), 1'b1, 1'b0);
        expect_out("reload_gap_b", 1'b1, 1'b0, 1'b0, bit_of(5));
        tick();
        drive(32'h0, 1'b0, 1'b0);
        expect_out("reload_a", 1'b0, 1'b0, 1'b0, bit_of(5));
        expect_out("reload_b1", 1'b1, 1'b0, 1'b0, bit_of(5));
        tick();
        expect_out("reload_b2", 1'b1, 1'b0, 1'b0, bit_of(5));
        tick();
        expect_out("reload_b_done", 1'b1, 1'b0, 1'b0, 32'h0);

        // asynchronous reset between edges drops everything at once
        pulse_reset();
        drive(mul_i(5'd4, 5'd1, 5'd2), 1'b1, 1'b0);
        tick();
        drive(lw_i(5'd5, 5'd2), 1'b1, 1'b0);
        tick();
        drive(add_i(5'd6, 5'd5, 5'd4), 1'b0, 1'b0);
        expect_out("pre_reset", 1'b0, 1'b1, 1'b1, bit_of(4) | bit_of(5));
        reset = 1'b1;
        #1;
        expect_out("async_reset", 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        tick();

        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL monitor_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised RAW/WAW hazard unit for the 5-stage 32-bit pipeline. It replaces the single-cycle load-use interlock with a per-register scoreboard. The scoreboard tracks loads with a configurable result latency and one in-flight multi-cycle mult/div. It sits beside the decode stage and drives the F/D and D/X stall, holding decode until every source and destination of the decode instruction is hazard-free.

## Interface
Parameters:
- NUM_REGS, 32, architectural register count; register 0 is never tracked.
- REG_W, 5, register index width.
- LOAD_LAT, 1, cycles after a load issues before a dependent instruction may issue; range 1..2^CNT_W-1.
- CNT_W, 2, width of each per-register countdown.

Ports:
- clock  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- decode_ir  in  32  instruction currently in decode.
- issue  in  1  decode instruction advances to execute this cycle; internally qualified with !stall.
- md_done  in  1  one-cycle pulse when the multdiv result is written back.
- stall  out  1  combinational; hold F/D, insert bubble into D/X.
- md_busy  out  1  registered; a mult/div is in flight.
- pending_mask  out  NUM_REGS  registered-derived; bit r set if r has a pending write.

## Operation
Field decode:
- opcode = ir[31:27], rd = ir[26:22], rs = ir[21:17], rt = ir[16:12], aluop = ir[6:2].

Sources read per opcode:
- 00000 (R-type): rs and rt.
- 00101 (addi), 01000 (lw): rs.
- 00111 (sw), 00010 (bne), 00110 (blt): rs and rd.
- 00100 (jr): rd.
- 10110 (bex): r30.
- All other opcodes read no sources.

Destination written:
- rd for R-type, addi and lw.
- r31 for 00011 (jal).
- r30 for 10101 (setx).
- Writes to r0 are ignored.

Mult/div: an R-type with aluop 00110 or 00111.

State:
- cnt[r], CNT_W bits, for r = 1..NUM_REGS-1.
- md_busy, 1 bit.
- md_rd, REG_W bits.

Updates on each clock edge, where go = issue & !stall:
- Every nonzero cnt[r] decrements by 1.
- go with lw and rd≠0: cnt[rd] <= LOAD_LAT. The load setting overrides that register's decrement in the same cycle.
- go with mult/div and rd≠0: md_busy <= 1, md_rd <= rd.
- md_done: md_busy <= 0. If go with a mult/div occurs in the same cycle, the new issue wins: md_busy stays 1 and md_rd takes the new rd.

stall is the OR of:
- Load RAW: any source s≠0 with cnt[s]≠0.
- Multdiv RAW: md_busy & !md_done & any source equals md_rd.
- WAW: md_busy & !md_done & destination equals md_rd.
- Structural: md_busy & !md_done & decode is a mult/div.

Other rules:
- Register 0 never causes a stall.
- md_done bypasses the multdiv hazards in its own cycle, because the writeback value is forwarded.
- pending_mask[r] = (cnt[r]≠0) | (md_busy & md_rd==r); bit 0 is always 0.

## Timing
- Reset, asynchronous: all cnt = 0, md_busy = 0, md_rd = 0, pending_mask = 0. stall therefore evaluates to 0 for any decode_ir.
- Reset asserted mid-operation discards all pending hazards immediately, without waiting for a clock edge.
- stall has zero latency from decode_ir and state. There is no registered stall.
- A load issued at edge t with LOAD_LAT = L blocks dependents for exactly L cycles; the first dependent issue is at edge t+L+1. L = 1 reproduces the classic load-use single bubble.
- A mult/div issued at edge t blocks dependents until the cycle in which md_done is high, inclusive of bypass; the dependent may issue at that same edge.
- issue while stall = 1 causes no state change.

## Test plan
- Load-use, L=1: issue lw r5,0(r2), then decode add r6,r5,r1 -> stall=1 for 1 cycle, 0 the next; pending_mask[5] is 1 for exactly 1 cycle.
- Latency 2 (LOAD_LAT=2): lw r7, then decode sw r7,0(r3) -> stall high 2 cycles. Decode add r8,r9,r10 instead -> stall 0.
- Multdiv: issue mul r4,r1,r2; decode add r3,r4,r4 -> stall held for 10 cycles until md_done. stall=0 in the md_done cycle, and add issues at that edge.
- Structural/WAW: md_busy with md_rd=4; decode div r9,r1,r2 -> stall. Decode addi r4,r0,1 -> stall. In the md_done cycle, issue a new mul r12 -> md_busy stays 1, md_rd=12.
- Register 0 and reload: lw r0 -> pending_mask=0 and no stall. lw r5 issued twice back-to-back with an independent instruction between -> cnt[5] reloads to LOAD_LAT.
- Reset mid-flight: md_busy=1 and cnt[5]=1; assert reset between edges -> stall, md_busy and pending_mask drop to 0 at once.
